// File: rtl/vend_disp_pkg.sv
// -----------------------------------------------------------------------------
// vend_disp_pkg
// Shared definitions for the vending dispense controller slice.
//   - State encodings for the vend channel and the change channel FSMs.
//   - Default timing constants (jam timeout, coin pulse high/low lengths).
//   - cntW(): width helper sizing a counter that must reach n-1.
// No ports (package).
// -----------------------------------------------------------------------------
package vend_disp_pkg;

  typedef enum logic [1:0] {
    V_IDLE  = 2'd0,
    V_RUN   = 2'd1,
    V_FAULT = 2'd2
  } vend_state_e;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_PULSE = 2'd1,
    C_GAP   = 2'd2
  } chg_state_e;

  localparam int DEF_PEND_W      = 3;
  localparam int DEF_TIMEOUT_CYC = 32;
  localparam int DEF_COIN_PULSE  = 4;
  localparam int DEF_COIN_GAP    = 4;

  // Bits needed for a counter running 0..n-1 (never less than one bit).
  function automatic int cntW(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/vend_coin_pulser.sv
// -----------------------------------------------------------------------------
// vend_coin_pulser
// Change channel: counts pending change requests and drives the change
// solenoid with one fixed-length pulse per coin, each followed by a fixed low
// gap. Runs independently of the vend channel.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   ret_i              : one-cycle change request
//   coin_out_o         : change solenoid drive (registered)
//   ovf_o              : request lost this cycle because the counter was full
//   busy_o             : pending count nonzero or FSM not idle
// -----------------------------------------------------------------------------
module vend_coin_pulser
  import vend_disp_pkg::*;
#(
  parameter int PEND_W     = DEF_PEND_W,
  parameter int COIN_PULSE = DEF_COIN_PULSE,
  parameter int COIN_GAP   = DEF_COIN_GAP
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic ret_i,
  output logic coin_out_o,
  output logic ovf_o,
  output logic busy_o
);

  localparam int CNT_W = cntW((COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP);

  chg_state_e        state_q;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              coin_q;
  logic              take;

  // A coin is started (and the request consumed) whenever the FSM is idle
  // with something queued.
  assign take = (state_q == C_IDLE) && (pend_q != '0);

  // Pending counter: simultaneous request and consume cancel out; a request
  // arriving while full is dropped and reported.
  always_comb begin
    pend_d = pend_q;
    ovf_o  = 1'b0;
    if (ret_i && !take) begin
      if (&pend_q) ovf_o = 1'b1;
      else         pend_d = pend_q + 1'b1;
    end else if (!ret_i && take) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pend_q <= '0;
    else            pend_q <= pend_d;
  end

  // Coin FSM: high for COIN_PULSE cycles, low for COIN_GAP cycles, then one
  // idle cycle before the next coin may start.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
      coin_q  <= 1'b0;
    end else begin
      case (state_q)
        C_IDLE: begin
          if (take) begin
            state_q <= C_PULSE;
            coin_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        C_PULSE: begin
          if (cnt_q == CNT_W'(COIN_PULSE - 1)) begin
            state_q <= C_GAP;
            coin_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        C_GAP: begin
          if (cnt_q == CNT_W'(COIN_GAP - 1)) begin
            state_q <= C_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= C_IDLE;
          coin_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign coin_out_o = coin_q;
  assign busy_o     = (pend_q != '0) || (state_q != C_IDLE);

endmodule

// File: rtl/vend_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// vend_dispense_ctrl
// Downstream of the vending FSM: queues sell and change requests, runs the
// product motor until the drop sensor confirms a dispense (or declares a jam
// on timeout), and drives the change solenoid through vend_coin_pulser.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   coke, ret          : one-cycle sell / change requests
//   drop_sense         : asynchronous product-drop sensor level
//   fault_clr          : one-cycle jam clear (only acts while jammed)
//   motor_on, coin_out : actuator drives
//   vend_done          : one-cycle pulse per successful dispense
//   fault              : sticky jam flag
//   ovf                : sticky flag, a request was lost to a full counter
//   busy               : anything queued or either channel active
//   vend_total, jam_total : statistics, present only with VEND_STAT_EN
// Optional feature macro: VEND_STAT_EN
// -----------------------------------------------------------------------------
module vend_dispense_ctrl
  import vend_disp_pkg::*;
#(
  parameter int PEND_W      = DEF_PEND_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int COIN_PULSE  = DEF_COIN_PULSE,
  parameter int COIN_GAP    = DEF_COIN_GAP
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        coke,
  input  logic        ret,
  input  logic        drop_sense,
  input  logic        fault_clr,
  output logic        motor_on,
  output logic        coin_out,
  output logic        vend_done,
  output logic        fault,
  output logic        ovf,
  output logic        busy
`ifdef VEND_STAT_EN
  ,
  output logic [15:0] vend_total,
  output logic [7:0]  jam_total
`endif
);

  localparam int TMR_W = cntW(TIMEOUT_CYC);

  logic              ds1_q, ds_s_q;
  vend_state_e       vstate_q;
  logic [PEND_W-1:0] vend_pend_q, vend_pend_d;
  logic [TMR_W-1:0]  timer_q;
  logic              motor_q, done_q, fault_q, ovf_q;
  logic              vend_take, vend_ok, vend_jam, vend_ovf_ev;
  logic              chg_ovf_ev, chg_busy;

  // Two-flop synchroniser; nothing downstream looks at raw drop_sense.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ds1_q  <= 1'b0;
      ds_s_q <= 1'b0;
    end else begin
      ds1_q  <= drop_sense;
      ds_s_q <= ds1_q;
    end
  end

  assign vend_take = (vstate_q == V_IDLE) && (vend_pend_q != '0);
  // A drop seen on the timeout cycle still counts as a success.
  assign vend_ok   = (vstate_q == V_RUN) && ds_s_q;
  assign vend_jam  = (vstate_q == V_RUN) && !ds_s_q &&
                     (timer_q == TMR_W'(TIMEOUT_CYC - 1));

  // Vend pending counter; keeps queueing while jammed.
  always_comb begin
    vend_pend_d = vend_pend_q;
    vend_ovf_ev = 1'b0;
    if (coke && !vend_take) begin
      if (&vend_pend_q) vend_ovf_ev = 1'b1;
      else              vend_pend_d = vend_pend_q + 1'b1;
    end else if (!coke && vend_take) begin
      vend_pend_d = vend_pend_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) vend_pend_q <= '0;
    else            vend_pend_q <= vend_pend_d;
  end

  // Vend FSM with registered motor, done pulse and jam flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vstate_q <= V_IDLE;
      timer_q  <= '0;
      motor_q  <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (vstate_q)
        V_IDLE: begin
          if (vend_take) begin
            vstate_q <= V_RUN;
            motor_q  <= 1'b1;
            timer_q  <= '0;
          end
        end
        V_RUN: begin
          if (vend_ok) begin
            vstate_q <= V_IDLE;
            motor_q  <= 1'b0;
            done_q   <= 1'b1;
          end else if (vend_jam) begin
            vstate_q <= V_FAULT;
            motor_q  <= 1'b0;
            fault_q  <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        V_FAULT: begin
          motor_q <= 1'b0;
          if (fault_clr) begin
            vstate_q <= V_IDLE;
            fault_q  <= 1'b0;
          end
        end
        default: begin
          vstate_q <= V_IDLE;
          motor_q  <= 1'b0;
          fault_q  <= 1'b0;
        end
      endcase
    end
  end

  // Overflow from either channel latches until reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) ovf_q <= 1'b0;
    else if (vend_ovf_ev || chg_ovf_ev) ovf_q <= 1'b1;
  end

  vend_coin_pulser #(
    .PEND_W    (PEND_W),
    .COIN_PULSE(COIN_PULSE),
    .COIN_GAP  (COIN_GAP)
  ) u_coin (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ret_i     (ret),
    .coin_out_o(coin_out),
    .ovf_o     (chg_ovf_ev),
    .busy_o    (chg_busy)
  );

`ifdef VEND_STAT_EN
  logic [15:0] vend_total_q;
  logic [7:0]  jam_total_q;

  // Dispense count wraps; jam count sticks at its maximum.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vend_total_q <= '0;
      jam_total_q  <= '0;
    end else begin
      if (vend_ok)                   vend_total_q <= vend_total_q + 16'd1;
      if (vend_jam && !(&jam_total_q)) jam_total_q <= jam_total_q + 8'd1;
    end
  end

  assign vend_total = vend_total_q;
  assign jam_total  = jam_total_q;
`endif

  assign motor_on  = motor_q;
  assign vend_done = done_q;
  assign fault     = fault_q;
  assign ovf       = ovf_q;
  assign busy      = (vend_pend_q != '0) || (vstate_q != V_IDLE) || chg_busy;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_dispense_ctrl
// Bench for vend_dispense_ctrl. Each stimulus cycle pushes the expected output
// vector {motor_on, coin_out, vend_done, fault, ovf, busy} onto a scoreboard
// queue; it is popped and compared one time unit after the next rising edge.
// -----------------------------------------------------------------------------
module tb_vend_dispense_ctrl;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic coke = 1'b0, ret = 1'b0, drop_sense = 1'b0, fault_clr = 1'b0;
  logic motor_on, coin_out, vend_done, fault, ovf, busy;
`ifdef VEND_STAT_EN
  logic [15:0] vend_total;
  logic [7:0]  jam_total;
`endif

  vend_dispense_ctrl dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .coke      (coke),
    .ret       (ret),
    .drop_sense(drop_sense),
    .fault_clr (fault_clr),
    .motor_on  (motor_on),
    .coin_out  (coin_out),
    .vend_done (vend_done),
    .fault     (fault),
    .ovf       (ovf),
    .busy      (busy)
`ifdef VEND_STAT_EN
    ,
    .vend_total(vend_total),
    .jam_total (jam_total)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string      name;
    logic       coke;
    logic       ret;
    logic       drop;
    logic       fclr;
    logic [5:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] exp;
  } sb_t;

  sb_t  sbQ[$];
  vec_t vecs[20];
  int   checks = 0;
  int   errors = 0;

  // Pop the oldest expectation and compare against the live outputs.
  task automatic checkOutput();
    sb_t        e;
    logic [5:0] act;
    checks++;
    if (sbQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: no expected vector queued");
      return;
    end
    e   = sbQ.pop_front();
    act = {motor_on, coin_out, vend_done, fault, ovf, busy};
    if (act !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual=%b required=%b (motor,coin,done,fault,ovf,busy)",
               e.name, $time, act, e.exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected result, check after the edge.
  task automatic applyStimulus(input string name, input logic c, input logic r,
                               input logic d, input logic f, input logic [5:0] exp);
    sb_t e;
    @(negedge sys_clk);
    coke       = c;
    ret        = r;
    drop_sense = d;
    fault_clr  = f;
    e.name = name;
    e.exp  = exp;
    sbQ.push_back(e);
    @(posedge sys_clk);
    #1;
    checkOutput();
  endtask

  // Assert reset away from the clock edge; outputs must clear without an edge.
  task automatic doReset();
    sb_t e;
    @(negedge sys_clk);
    sys_rst_n  = 1'b0;
    coke       = 1'b0;
    ret        = 1'b0;
    drop_sense = 1'b0;
    fault_clr  = 1'b0;
    #1;
    e.name = "reset_outputs";
    e.exp  = 6'b000000;
    sbQ.push_back(e);
    checkOutput();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  // Safety net so a wedged run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Table: single sell with drop, then simultaneous sell + change.
    vecs[0]  = '{"cokeA_queued",   1'b1, 1'b0, 1'b0, 1'b0, 6'b000001};
    vecs[1]  = '{"cokeA_motor",    1'b0, 1'b0, 1'b0, 1'b0, 6'b100001};
    vecs[2]  = '{"cokeA_run",      1'b0, 1'b0, 1'b0, 1'b0, 6'b100001};
    vecs[3]  = '{"cokeA_drop1",    1'b0, 1'b0, 1'b1, 1'b0, 6'b100001};
    vecs[4]  = '{"cokeA_drop2",    1'b0, 1'b0, 1'b1, 1'b0, 6'b100001};
    vecs[5]  = '{"cokeA_done",     1'b0, 1'b0, 1'b1, 1'b0, 6'b001000};
    vecs[6]  = '{"cokeA_idle1",    1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[7]  = '{"cokeA_idle2",    1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[8]  = '{"cokeA_idle3",    1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[9]  = '{"both_queued",    1'b1, 1'b1, 1'b0, 1'b0, 6'b000001};
    vecs[10] = '{"both_start",     1'b0, 1'b0, 1'b0, 1'b0, 6'b110001};
    vecs[11] = '{"both_run1",      1'b0, 1'b0, 1'b0, 1'b0, 6'b110001};
    vecs[12] = '{"both_run2",      1'b0, 1'b0, 1'b0, 1'b0, 6'b110001};
    vecs[13] = '{"both_run3",      1'b0, 1'b0, 1'b1, 1'b0, 6'b110001};
    vecs[14] = '{"both_gap",       1'b0, 1'b0, 1'b1, 1'b0, 6'b100001};
    vecs[15] = '{"both_done",      1'b0, 1'b0, 1'b0, 1'b0, 6'b001001};
    vecs[16] = '{"both_gap2",      1'b0, 1'b0, 1'b0, 1'b0, 6'b000001};
    vecs[17] = '{"both_gap3",      1'b0, 1'b0, 1'b0, 1'b0, 6'b000001};
    vecs[18] = '{"both_idle",      1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[19] = '{"fclr_ignored",   1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};

    doReset();
    for (int i = 0; i < 20; i++)
      applyStimulus(vecs[i].name, vecs[i].coke, vecs[i].ret, vecs[i].drop,
                    vecs[i].fclr, vecs[i].exp);

    // Jam timeout: motor runs 32 cycles, then sticky fault; a sell queues.
    doReset();
    applyStimulus("to_coke", 1'b1, 1'b0, 1'b0, 1'b0, 6'b000001);
    for (int k = 0; k < 32; k++)
      applyStimulus("to_motor", 1'b0, 1'b0, 1'b0, 1'b0, 6'b100001);
    applyStimulus("to_fault",      1'b0, 1'b0, 1'b0, 1'b0, 6'b000101);
    applyStimulus("to_fault_coke", 1'b1, 1'b0, 1'b0, 1'b0, 6'b000101);
    applyStimulus("to_fault_hold", 1'b0, 1'b0, 1'b0, 1'b0, 6'b000101);
    applyStimulus("to_fault_hold", 1'b0, 1'b0, 1'b0, 1'b0, 6'b000101);
    applyStimulus("to_fault_clr",  1'b0, 1'b0, 1'b0, 1'b1, 6'b000001);
    applyStimulus("to_restart",    1'b0, 1'b0, 1'b1, 1'b0, 6'b100001);
    applyStimulus("to_restart_run",1'b0, 1'b0, 1'b1, 1'b0, 6'b100001);
    applyStimulus("to_restart_done",1'b0,1'b0, 1'b0, 1'b0, 6'b001000);
    applyStimulus("to_idle",       1'b0, 1'b0, 1'b0, 1'b0, 6'b000000);

    // Three back-to-back change requests: coins start every 9 cycles.
    doReset();
    applyStimulus("chg_first", 1'b0, 1'b1, 1'b0, 1'b0, 6'b000001);
    for (int k = 0; k < 30; k++) begin
      logic c, b;
      c = ((k % 9) < 4) && (k < 27);
      b = (k < 26);
      applyStimulus("chg_train", 1'b0, (k < 2), 1'b0, 1'b0,
                    {1'b0, c, 1'b0, 1'b0, 1'b0, b});
    end

    // Jam lands in the middle of a coin pulse; coin pulse is unaffected.
    doReset();
    applyStimulus("mix_coke", 1'b1, 1'b0, 1'b0, 1'b0, 6'b000001);
    for (int k = 0; k < 41; k++) begin
      logic m, c, f;
      m = (k < 32);
      c = (k >= 29) && (k <= 32);
      f = (k >= 32);
      applyStimulus("mix_jam_coin", 1'b0, (k == 28), 1'b0, 1'b0,
                    {m, c, 1'b0, f, 1'b0, 1'b1});
    end

    // Overflow while jammed, then seven dispenses drain the saturated queue.
    doReset();
    applyStimulus("ovf_coke", 1'b1, 1'b0, 1'b0, 1'b0, 6'b000001);
    for (int k = 0; k < 32; k++)
      applyStimulus("ovf_motor", 1'b0, 1'b0, 1'b0, 1'b0, 6'b100001);
    applyStimulus("ovf_fault", 1'b0, 1'b0, 1'b0, 1'b0, 6'b000101);
    for (int i = 0; i < 8; i++)
      applyStimulus("ovf_queue", 1'b1, 1'b0, 1'b0, 1'b0,
                    (i < 7) ? 6'b000101 : 6'b000111);
    applyStimulus("ovf_clr", 1'b0, 1'b0, 1'b0, 1'b1, 6'b000011);
    for (int i = 0; i < 7; i++) begin
      applyStimulus("ovf_disp_start", 1'b0, 1'b0, 1'b1, 1'b0, 6'b100011);
      applyStimulus("ovf_disp_run",   1'b0, 1'b0, 1'b1, 1'b0, 6'b100011);
      applyStimulus("ovf_disp_done",  1'b0, 1'b0, 1'b0, 1'b0,
                    {4'b0010, 1'b1, (i < 6)});
    end
    applyStimulus("ovf_sticky", 1'b0, 1'b0, 1'b0, 1'b0, 6'b000010);
`ifdef VEND_STAT_EN
    checks++;
    if (vend_total !== 16'd7) begin
      errors++;
      $display("[TB] FAIL vend_total: actual=%0d required=7", vend_total);
    end
    checks++;
    if (jam_total !== 8'd1) begin
      errors++;
      $display("[TB] FAIL jam_total: actual=%0d required=1", jam_total);
    end
`endif

    // Reset in the middle of a motor run and a coin pulse discards the queue.
    doReset();
    applyStimulus("rst_both",  1'b1, 1'b1, 1'b0, 1'b0, 6'b000001);
    applyStimulus("rst_run",   1'b1, 1'b0, 1'b0, 1'b0, 6'b110001);
    applyStimulus("rst_run2",  1'b0, 1'b1, 1'b0, 1'b0, 6'b110001);
    doReset();
    for (int k = 0; k < 12; k++)
      applyStimulus("rst_discarded", 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
